// File: rtl/sensor_hit_detector.sv
// Synchronises, debounces and latches the Arduino box code, then flags one match/miss per physical hit.
// Latency: hit_pulse registered DEBOUNCE_CYCLES+2 edges after a steady code; no backpressure, pulses are one cycle.
module sensor_hit_detector #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [2:0]       GPIO_1,
  input  logic [2:0]       target_box,
  output logic             hit_pulse,
  output logic             match_pulse,
  output logic             miss_pulse,
  output logic [2:0]       box_addr,
  output logic             busy,
  output logic [7:0]       hit_count
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       s1, s2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       cand, cand_n;
  logic             hit_n, match_n, miss_n;
  logic [2:0]       box_n;
  logic [7:0]       count_n;

  assign busy = (state != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1          <= 3'd0;
      s2          <= 3'd0;
      state       <= IDLE;
      cnt         <= '0;
      cand        <= 3'd0;
      hit_pulse   <= 1'b0;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      box_addr    <= 3'd0;
      hit_count   <= 8'd0;
    end else begin
      s1          <= GPIO_1;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      cand        <= cand_n;
      hit_pulse   <= hit_n;
      match_pulse <= match_n;
      miss_pulse  <= miss_n;
      box_addr    <= box_n;
      hit_count   <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    hit_n   = 1'b0;
    match_n = 1'b0;
    miss_n  = 1'b0;
    box_n   = box_addr;
    count_n = hit_count;
    case (state)
      IDLE: begin
        if (s2 != 3'd0) begin
          cand_n  = s2;
          cnt_n   = CNT_ONE;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s2 == 3'd0) begin
          state_n = IDLE;
        end else if (s2 != cand) begin
          // A different box mid-debounce restarts the hold time on the new code.
          cand_n = s2;
          cnt_n  = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          box_n   = cand;
          hit_n   = 1'b1;
          match_n = (target_box != 3'd0) && (cand == target_box);
          miss_n  = (target_box != 3'd0) && (cand != target_box);
          if (hit_count != 8'hFF) count_n = hit_count + 8'd1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (s2 == 3'd0) begin
          cnt_n   = CNT_ONE;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (s2 != 3'd0) begin
          state_n = HELD;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
